// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one external single-port data RAM between NUM_REQ requesters
// (for example port 0 = load/store unit, port 1 = debug/DMA loader).
// Every access takes two states: IDLE arbitrates and latches the winning
// request into the RAM-facing registers, then ACCESS drives the RAM for
// exactly one cycle. The read data is captured at the end of ACCESS and
// returned with a one-cycle, one-hot ack.
//
// A port whose ack is high is left out of arbitration for that cycle. This
// lets a requester that keeps req asserted start its next transaction
// cleanly, and it also gives other ports a turn.
//
// Optional feature (compile-time macro RAM_ARB_FIXED_PRI_EN):
//   defined   : fixed priority, the lowest eligible index always wins and
//               no round-robin pointer exists.
//   undefined : round-robin, starting from port 0 after reset.
//
// Parameters:
//   NUM_REQ  number of requesters (2..4)
//   AW       RAM address width
//   DW       RAM data width
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req        per-port request level
//   we_in      per-port write enable (1 = write, 0 = read)
//   addr_in    per-port address, port i at [i*AW +: AW]
//   wdata_in   per-port write data, port i at [i*DW +: DW]
//   ack        one-hot, one-cycle completion pulse
//   rdata      read data, valid while any ack bit is high
//   busy       high while in ACCESS
//   ram_addr   RAM address (registered)
//   ram_d      RAM write data (registered)
//   ram_we     RAM write enable (registered)
//   ram_q      RAM combinational read data
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 10,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we_in,
  input  logic [NUM_REQ*AW-1:0] addr_in,
  input  logic [NUM_REQ*DW-1:0] wdata_in,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic [AW-1:0]         ram_addr,
  output logic [DW-1:0]         ram_d,
  output logic                  ram_we,
  input  logic [DW-1:0]         ram_q
);

  // Port index width; NUM_REQ is limited to 2..4.
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0] addr_arr  [NUM_REQ];
  logic [DW-1:0] wdata_arr [NUM_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      gnt_idx;

  // Split the flat per-port buses into arrays so the winner's fields can be
  // picked with a plain index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_in[g*AW +: AW];
    assign wdata_arr[g] = wdata_in[g*DW +: DW];
  end

  // A port being acked this cycle has its req still high from the finished
  // transaction, so it must not be re-granted on the same request.
  assign eligible = req & ~ack;

  assign busy = (state == ACCESS);

`ifdef RAM_ARB_FIXED_PRI_EN

  // Fixed priority: scan from the top down so the lowest eligible index is
  // the last assignment and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
      end
    end
  end

`else

  logic [IW-1:0] rr;
  logic [IW-1:0] rr_next;
  int            scan;

  // Round-robin: scan rr, rr+1, ... modulo NUM_REQ and take the first
  // eligible port. The wrap is done by subtraction so non-power-of-two
  // port counts work.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr) + k;
      if (scan >= NUM_REQ) begin
        scan = scan - NUM_REQ;
      end
      if (!win_found && eligible[IW'(scan)]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan);
      end
    end
  end

  // The pointer moves just past the winner so that port gets lowest
  // priority in the next arbitration.
  always_comb begin
    rr_next = rr;
    if (state == IDLE && win_found) begin
      if (int'(win_idx) == NUM_REQ - 1) begin
        rr_next = '0;
      end else begin
        rr_next = win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else begin
      rr <= rr_next;
    end
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ACCESS always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM-facing registers, read-data capture and ack generation. The async
  // reset clears ram_we at once, so a reset during ACCESS suppresses the
  // write that would otherwise commit at the next edge. rdata is captured
  // for writes as well, which returns the contents before the write.
  // ram_addr and ram_d keep their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      rdata    <= '0;
      ram_addr <= '0;
      ram_d    <= '0;
      ram_we   <= 1'b0;
      gnt_idx  <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            ram_addr <= addr_arr[win_idx];
            ram_d    <= wdata_arr[win_idx];
            ram_we   <= we_in[win_idx];
            gnt_idx  <= win_idx;
          end else begin
            ram_we <= 1'b0;
          end
        end
        ACCESS: begin
          rdata        <= ram_q;
          ack[gnt_idx] <= 1'b1;
          ram_we       <= 1'b0;
        end
        default: begin
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
